// File: rtl/press_classifier.sv
// Turns the debounced button level into one-cycle short, double, long and
// auto-repeat events, plus a press_rise edge pulse, all registered on clk_100hz.
module press_classifier #(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter int DBL_TICKS    = 30
) (
    input  logic       clk_100hz,
    input  logic       rst,
    input  logic       pb_debounced,
    output logic       press_rise,
    output logic       short_press,
    output logic       double_press,
    output logic       long_press,
    output logic       repeat_tick,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Terminal counts; every compare lands before the 8-bit counters could wrap.
    localparam logic [7:0] LONG_LAST   = 8'(LONG_TICKS - 1);
    localparam logic [7:0] REPEAT_LAST = 8'(REPEAT_TICKS - 1);
    localparam logic [7:0] DBL_LAST    = 8'(DBL_TICKS - 1);

    state_t     st;
    logic       pb_prev;
    logic [7:0] cnt;
    logic [7:0] rep_cnt;

    assign state = st;

    always_ff @(posedge clk_100hz or negedge rst) begin
        if (!rst) begin
            st           <= IDLE;
            pb_prev      <= 1'b0;
            cnt          <= 8'd0;
            rep_cnt      <= 8'd0;
            press_rise   <= 1'b0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_tick  <= 1'b0;
        end else begin
            pb_prev      <= pb_debounced;
            press_rise   <= pb_debounced & ~pb_prev;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_tick  <= 1'b0;

            case (st)
                IDLE: begin
                    if (pb_debounced) begin
                        st  <= PRESS1;
                        cnt <= 8'd0;
                    end
                end

                PRESS1: begin
                    if (pb_debounced) begin
                        if (cnt == LONG_LAST) begin
                            long_press <= 1'b1;
                            st         <= HOLD;
                            rep_cnt    <= 8'd0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end else begin
                        st  <= WAIT2;
                        cnt <= 8'd0;
                    end
                end

                // A press on the final window cycle still wins over the short event.
                WAIT2: begin
                    if (pb_debounced) begin
                        st <= PRESS2;
                    end else if (cnt == DBL_LAST) begin
                        short_press <= 1'b1;
                        st          <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                // Second press has no hold limit and never escalates to long_press.
                PRESS2: begin
                    if (!pb_debounced) begin
                        double_press <= 1'b1;
                        st           <= IDLE;
                    end
                end

                HOLD: begin
                    if (!pb_debounced) begin
                        st <= IDLE;
                    end else if (rep_cnt == REPEAT_LAST) begin
                        repeat_tick <= 1'b1;
                        rep_cnt     <= 8'd0;
                    end else begin
                        rep_cnt <= rep_cnt + 8'd1;
                    end
                end

                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with default parameters (100/20/30).
module tb_press_classifier;

    logic       clk_100hz = 1'b0;
    logic       rst;
    logic       pb_debounced;
    logic       press_rise;
    logic       short_press;
    logic       double_press;
    logic       long_press;
    logic       repeat_tick;
    logic [2:0] state;

    press_classifier dut (
        .clk_100hz    (clk_100hz),
        .rst          (rst),
        .pb_debounced (pb_debounced),
        .press_rise   (press_rise),
        .short_press  (short_press),
        .double_press (double_press),
        .long_press   (long_press),
        .repeat_tick  (repeat_tick),
        .state        (state)
    );

    always #5 clk_100hz = ~clk_100hz;

    int checks   = 0;
    int failures = 0;

    int edge_n = 0;
    int n_rise, n_short, n_dbl, n_long, n_rep, n_multi;
    int e_short, e_dbl, e_long, e_rep_first, e_rep_last;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        n_rise = 0; n_short = 0; n_dbl = 0; n_long = 0; n_rep = 0; n_multi = 0;
        e_short = -1; e_dbl = -1; e_long = -1; e_rep_first = -1; e_rep_last = -1;
    endtask

    // Called 1 time unit after each rising edge; edge_n names that edge.
    task automatic sample();
        int s;
        s = int'(short_press) + int'(double_press) + int'(long_press) + int'(repeat_tick);
        if (s > 1 || (press_rise && short_press)) n_multi++;
        if (press_rise) n_rise++;
        if (short_press) begin
            if (n_short == 0) e_short = edge_n;
            n_short++;
        end
        if (double_press) begin
            if (n_dbl == 0) e_dbl = edge_n;
            n_dbl++;
        end
        if (long_press) begin
            if (n_long == 0) e_long = edge_n;
            n_long++;
        end
        if (repeat_tick) begin
            if (n_rep == 0) e_rep_first = edge_n;
            e_rep_last = edge_n;
            n_rep++;
        end
    endtask

    // Drive pb for n edges; each of those edges samples val.
    task automatic hold(input logic val, input int n);
        pb_debounced = val;
        repeat (n) begin
            @(posedge clk_100hz);
            edge_n++;
            #1;
            sample();
        end
    endtask

    int k, r;

    initial begin
        int multi_total;
        multi_total = 0;
        clr_counts();

        // Reset held with the button already pressed
        rst = 1'b0;
        pb_debounced = 1'b1;
        hold(1'b1, 3);
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_pulses", int'({press_rise, short_press, double_press, long_press, repeat_tick}), 0);
        rst = 1'b1;
        clr_counts();
        k = edge_n + 1;
        hold(1'b1, 1);
        check_eq("rel_rise", int'(press_rise), 1);
        check_eq("rel_state", int'(state), 1);
        hold(1'b1, 1);
        check_eq("rise_width", int'(press_rise), 0);

        // Short press: 10 high samples total, then release
        hold(1'b1, 8);
        r = edge_n + 1;
        hold(1'b0, 40);
        check_eq("short_cnt", n_short, 1);
        check_eq("short_edge", e_short, r + 30);
        check_eq("short_others", n_dbl + n_long + n_rep, 0);
        check_eq("short_rise", n_rise, 1);
        check_eq("short_state", int'(state), 0);
        multi_total += n_multi;

        // Double press, 15-cycle gap
        clr_counts();
        hold(1'b1, 10);
        hold(1'b0, 15);
        hold(1'b1, 5);
        r = edge_n + 1;
        hold(1'b0, 40);
        check_eq("dbl_cnt", n_dbl, 1);
        check_eq("dbl_edge", e_dbl, r);
        check_eq("dbl_noshort", n_short, 0);
        check_eq("dbl_rise", n_rise, 2);
        multi_total += n_multi;

        // Gap = low samples after the release edge; 29 lands on the last window cycle
        clr_counts();
        hold(1'b1, 10);
        hold(1'b0, 30);
        hold(1'b1, 5);
        hold(1'b0, 40);
        check_eq("gap29_dbl", n_dbl, 1);
        check_eq("gap29_short", n_short, 0);
        multi_total += n_multi;

        // Gap 30: window expires, second press starts afresh
        clr_counts();
        hold(1'b1, 10);
        r = edge_n + 1;
        hold(1'b0, 31);
        check_eq("gap30_short_edge", e_short, r + 30);
        hold(1'b1, 1);
        check_eq("gap30_new_press1", int'(state), 1);
        hold(1'b1, 4);
        hold(1'b0, 40);
        check_eq("gap30_short_cnt", n_short, 2);
        check_eq("gap30_dbl", n_dbl, 0);
        multi_total += n_multi;

        // Long press with auto-repeat: edges k..k+200 sample high
        clr_counts();
        k = edge_n + 1;
        hold(1'b1, 201);
        check_eq("long_cnt", n_long, 1);
        check_eq("long_edge", e_long, k + 100);
        check_eq("rep_cnt", n_rep, 5);
        check_eq("rep_first", e_rep_first, k + 120);
        check_eq("rep_last", e_rep_last, k + 200);
        check_eq("hold_state", int'(state), 4);
        hold(1'b0, 40);
        check_eq("long_noshort", n_short + n_dbl, 0);
        check_eq("long_state", int'(state), 0);
        multi_total += n_multi;

        // Released on the cnt == LONG_TICKS-1 edge: short, not long
        clr_counts();
        k = edge_n + 1;
        hold(1'b1, 100);
        r = edge_n + 1;
        hold(1'b0, 40);
        check_eq("b99_long", n_long, 0);
        check_eq("b99_short", n_short, 1);
        check_eq("b99_short_edge", e_short, r + 30);
        check_eq("b99_release_edge", r, k + 100);
        multi_total += n_multi;

        // Still high on that edge: long
        clr_counts();
        k = edge_n + 1;
        hold(1'b1, 101);
        check_eq("b100_long", n_long, 1);
        check_eq("b100_long_edge", e_long, k + 100);
        hold(1'b0, 40);
        check_eq("b100_short", n_short, 0);
        multi_total += n_multi;

        // Reset during WAIT2 discards the pending short press
        clr_counts();
        hold(1'b1, 10);
        hold(1'b0, 10);
        check_eq("w2_state", int'(state), 2);
        rst = 1'b0;
        #1;
        check_eq("w2_rst_state", int'(state), 0);
        hold(1'b0, 3);
        rst = 1'b1;
        clr_counts();
        hold(1'b0, 50);
        check_eq("w2_rst_short", n_short, 0);
        check_eq("w2_rst_events", n_rise + n_dbl + n_long + n_rep, 0);

        // Reset during HOLD stops the repeat stream
        clr_counts();
        hold(1'b1, 110);
        check_eq("hold_entered", int'(state), 4);
        rst = 1'b0;
        pb_debounced = 1'b0;
        #1;
        check_eq("hold_rst_state", int'(state), 0);
        check_eq("hold_rst_pulses", int'({press_rise, short_press, double_press, long_press, repeat_tick}), 0);
        hold(1'b0, 3);
        rst = 1'b1;
        clr_counts();
        hold(1'b0, 50);
        check_eq("hold_rst_rep", n_rep, 0);
        check_eq("hold_rst_events", n_rise + n_short + n_dbl + n_long, 0);
        check_eq("hold_rst_state2", int'(state), 0);

        multi_total += n_multi;
        check_eq("exclusive_pulses", multi_total, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
